// File: rtl/rv_fetch_queue_if.sv
// Instruction bus: single-outstanding read request/acknowledge.
interface rv_fetch_queue_if;
  logic        bus_req;
  logic [29:0] bus_addr;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_addr,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_addr,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/rv_fetch_queue.sv
// Instruction-fetch front end: sequential word-PC generation, single-outstanding
// bus reads, and a prefetch FIFO of {pc, instr} feeding decode.
//
// state  | meaning
// S_IDLE | no read outstanding; issue when queue has room or on redirect
// S_REQ  | read outstanding; req/addr held until ack
module rv_fetch_queue #(
  parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_pc_sel,
  input  logic [29:0]         i_pc_target,
  rv_fetch_queue_if.master    bus,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_instr,
  output logic [29:0]         o_pc,
  output logic [29:0]         o_pc_p4,
  output logic [CNT_W-1:0]    o_count
);

  localparam int              PTR_W   = $clog2(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t           r_state, w_state_nxt;
  logic [29:0]      r_fetch_pc, w_fetch_pc_nxt;
  logic [29:0]      r_bus_addr, w_bus_addr_nxt;
  logic             r_discard, w_discard_nxt;
  logic             w_push;
  logic             w_pop;

  logic [61:0]      r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [61:0]      w_head;

  // Fetch state, fetch PC, held bus address and discard flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_ADDR[31:2];
      r_bus_addr <= RESET_ADDR[31:2];
      r_discard  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_bus_addr <= w_bus_addr_nxt;
      r_discard  <= w_discard_nxt;
    end
  end

  // Next-state: issue on room (registered count) or redirect; a redirect while
  // a read is in flight marks its response for dropping instead of pushing.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_bus_addr_nxt = r_bus_addr;
    w_discard_nxt  = r_discard;
    w_push         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_pc_sel) begin
          w_fetch_pc_nxt = i_pc_target;
          w_bus_addr_nxt = i_pc_target;
          w_state_nxt    = S_REQ;
        end else if (r_count < DEPTH_C) begin
          w_bus_addr_nxt = r_fetch_pc;
          w_state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.bus_ack) begin
          w_state_nxt   = S_IDLE;
          w_discard_nxt = 1'b0;
          if (i_pc_sel) begin
            w_fetch_pc_nxt = i_pc_target;
          end else if (!r_discard) begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_bus_addr + 30'd1;
          end
        end else if (i_pc_sel) begin
          w_discard_nxt  = 1'b1;
          w_fetch_pc_nxt = i_pc_target;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.bus_req  = (r_state == S_REQ);
  assign bus.bus_addr = r_bus_addr;

  assign w_pop = o_valid & i_ready & ~i_pc_sel;

  // Queue storage; no reset needed since occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= {r_bus_addr, bus.bus_rdata};
  end

  // Queue pointers and occupancy; redirect flushes.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_pc_sel) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  assign w_head  = r_mem[r_rptr];
  assign o_valid = (r_count != '0);
  assign o_instr = w_head[31:0];
  assign o_pc    = w_head[61:32];
  assign o_pc_p4 = w_head[61:32] + 30'd1;
  assign o_count = r_count;

endmodule

// File: tb/tb_rv_fetch_queue.sv
module tb_rv_fetch_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_sel = 1'b0;
  logic [29:0] pc_target = '0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] instr;
  logic [29:0] pc, pc_p4;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  rv_fetch_queue_if bus();

  rv_fetch_queue #(.RESET_ADDR(32'h0000_0100), .QUEUE_DEPTH(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_pc_sel(pc_sel), .i_pc_target(pc_target),
    .bus(bus), .o_valid(valid), .i_ready(ready), .o_instr(instr),
    .o_pc(pc), .o_pc_p4(pc_p4), .o_count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [29:0] a, input int exp_n);
    int n;
    n = 0;
    while (bus.bus_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.bus_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: req=%b after %0d cycles, expected 1", bus.bus_req, n);
    end else begin
      checks++;
      if (bus.bus_addr !== a) begin
        errors++;
        $display("FAIL req_addr: got %h expected %h", bus.bus_addr, a);
      end
      if (exp_n >= 0) begin
        checks++;
        if (n != exp_n) begin
          errors++;
          $display("FAIL req_latency: addr %h req after %0d cycles expected %0d", a, n, exp_n);
        end
      end
    end
  endtask

  task automatic serve(input logic [29:0] a, input logic [31:0] d, input int exp_n);
    wait_req(a, exp_n);
    bus.bus_ack   = 1'b1;
    bus.bus_rdata = d;
    tick();
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.bus_req !== 1'b0 || valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b count=%0d expected 0/0/0", bus.bus_req, valid, count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    ready = 1'b1;
    serve(30'h40, 32'hA000_0040, -1);
    checks++;
    if (valid !== 1'b1 || pc !== 30'h40 || instr !== 32'hA000_0040 || pc_p4 !== 30'h41 || count !== 3'd1) begin
      errors++;
      $display("FAIL seq_first: valid=%b pc=%h instr=%h p4=%h count=%0d expected 1/40/a0000040/41/1",
               valid, pc, instr, pc_p4, count);
    end
    serve(30'h41, 32'hA000_0041, 1);
    checks++;
    if (valid !== 1'b1 || pc !== 30'h41 || instr !== 32'hA000_0041) begin
      errors++;
      $display("FAIL seq_second: valid=%b pc=%h instr=%h expected 1/41/a0000041", valid, pc, instr);
    end
    serve(30'h42, 32'hA000_0042, 1);
    checks++;
    if (pc !== 30'h42 || count !== 3'd1) begin
      errors++;
      $display("FAIL seq_third: pc=%h count=%0d expected 42/1", pc, count);
    end
  endtask

  task automatic test_full();
    rst_n = 1'b0;
    ready = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) serve(30'h40 + 30'(i), 32'hB000_0000 + 32'(i), (i == 0) ? -1 : 1);
    checks++;
    if (count !== 3'd4 || pc !== 30'h40) begin
      errors++;
      $display("FAIL full_count: count=%0d pc=%h expected 4/40", count, pc);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.bus_req !== 1'b0) begin
        errors++;
        $display("FAIL full_no_req: req=%b at idle cycle %0d expected 0", bus.bus_req, i);
      end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++;
    if (count !== 3'd3 || bus.bus_req !== 1'b0 || pc !== 30'h41 || instr !== 32'hB000_0001) begin
      errors++;
      $display("FAIL full_pop: count=%0d req=%b pc=%h instr=%h expected 3/0/41/b0000001", count, bus.bus_req, pc, instr);
    end
    tick();
    checks++;
    if (bus.bus_req !== 1'b1 || bus.bus_addr !== 30'h44) begin
      errors++;
      $display("FAIL full_refill: req=%b addr=%h expected 1/44", bus.bus_req, bus.bus_addr);
    end
  endtask

  task automatic test_redirect_pending();
    pc_sel = 1'b1;
    pc_target = 30'h200;
    tick();
    pc_sel = 1'b0;
    checks++;
    if (count !== 3'd0 || valid !== 1'b0 || bus.bus_req !== 1'b1 || bus.bus_addr !== 30'h44) begin
      errors++;
      $display("FAIL redir_flush: count=%0d valid=%b req=%b addr=%h expected 0/0/1/44", count, valid, bus.bus_req, bus.bus_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.bus_req !== 1'b1 || bus.bus_addr !== 30'h44 || valid !== 1'b0) begin
        errors++;
        $display("FAIL redir_hold: req=%b addr=%h valid=%b expected 1/44/0", bus.bus_req, bus.bus_addr, valid);
      end
    end
    bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus.bus_ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || count !== 3'd0 || bus.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_drop: valid=%b count=%0d req=%b expected 0/0/0", valid, count, bus.bus_req);
    end
    tick();
    checks++;
    if (bus.bus_req !== 1'b1 || bus.bus_addr !== 30'h200 || valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_target: req=%b addr=%h valid=%b expected 1/200/0", bus.bus_req, bus.bus_addr, valid);
    end
    serve(30'h200, 32'hC000_0200, 0);
    checks++;
    if (valid !== 1'b1 || pc !== 30'h200 || instr !== 32'hC000_0200) begin
      errors++;
      $display("FAIL redir_first: valid=%b pc=%h instr=%h expected 1/200/c0000200", valid, pc, instr);
    end
  endtask

  task automatic test_redirect_ack_pop();
    serve(30'h201, 32'hC000_0201, 1);
    wait_req(30'h202, 1);
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL rap_setup: count=%0d expected 2", count);
    end
    bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'hC000_0202;
    ready = 1'b1;
    pc_sel = 1'b1;
    pc_target = 30'h300;
    tick();
    bus.bus_ack = 1'b0;
    ready = 1'b0;
    pc_sel = 1'b0;
    checks++;
    if (count !== 3'd0 || valid !== 1'b0 || bus.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL rap_flush: count=%0d valid=%b req=%b expected 0/0/0", count, valid, bus.bus_req);
    end
    tick();
    checks++;
    if (bus.bus_req !== 1'b1 || bus.bus_addr !== 30'h300) begin
      errors++;
      $display("FAIL rap_target: req=%b addr=%h expected 1/300", bus.bus_req, bus.bus_addr);
    end
    serve(30'h300, 32'hC000_0300, 0);
    checks++;
    if (pc !== 30'h300 || count !== 3'd1) begin
      errors++;
      $display("FAIL rap_push: pc=%h count=%0d expected 300/1", pc, count);
    end
  endtask

  task automatic test_wrap();
    pc_sel = 1'b1;
    pc_target = 30'h3FFF_FFFF;
    tick();
    pc_sel = 1'b0;
    checks++;
    if (bus.bus_req !== 1'b1 || bus.bus_addr !== 30'h3FFF_FFFF || count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_issue: req=%b addr=%h count=%0d expected 1/3fffffff/0", bus.bus_req, bus.bus_addr, count);
    end
    serve(30'h3FFF_FFFF, 32'hE000_0001, 0);
    checks++;
    if (pc !== 30'h3FFF_FFFF || pc_p4 !== 30'h0) begin
      errors++;
      $display("FAIL wrap_p4: pc=%h p4=%h expected 3fffffff/0", pc, pc_p4);
    end
    serve(30'h0, 32'hE000_0002, 1);
    checks++;
    if (count !== 3'd2 || pc !== 30'h3FFF_FFFF) begin
      errors++;
      $display("FAIL wrap_next: count=%0d pc=%h expected 2/3fffffff", count, pc);
    end
  endtask

  task automatic test_reset_pending();
    wait_req(30'h1, 1);
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.bus_req !== 1'b0 || count !== 3'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rstp_state: req=%b count=%0d valid=%b expected 0/0/0", bus.bus_req, count, valid);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.bus_req !== 1'b1 || bus.bus_addr !== 30'h40) begin
      errors++;
      $display("FAIL rstp_restart: req=%b addr=%h expected 1/40", bus.bus_req, bus.bus_addr);
    end
  endtask

  initial begin
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = '0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_full();
    test_redirect_pending();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
